uart_tx_engine: RTL

//  Transmit path of the UART core. It sits downstream of the register block and

---
 rtl/uart_tx_engine.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: 16-entry byte FIFO feeding a start/data/parity/stop serialiser.
// Define UART_TX_OVERRUN_FLAG_EN to build the sticky tf_overrun flag.
module uart_tx_engine #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_COUNTER_W = 5
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic [7:0]                lcr,
  input  logic                      tf_push,
  input  logic [7:0]                wb_dat_i,
  input  logic                      enable,
  input  logic                      tx_reset,
  input  logic                      lsr_mask,
  output logic                      stx_o,
  output logic [2:0]                tstate,
  output logic [FIFO_COUNTER_W-1:0] tf_count,
  output logic                      tf_overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_COUNTER_W-1:0] DEPTH_C = FIFO_COUNTER_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    POP    = 3'd5
  } state_t;

  logic [7:0]                fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_COUNTER_W-1:0] count_q, count_d;
  logic                      push_ok, pop_ok;

  state_t      state_q, state_d;
  logic [4:0]  tick_q, tick_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [1:0]  wlen_q, wlen_d;
  logic        pen_q, pen_d;
  logic        stop_q, stop_d;
  logic        stx_q, stx_d;

  logic [7:0]  head;
  logic [7:0]  data_mask;
  logic [4:0]  stop_ticks;
  logic        advance;
  logic        last_bit;
  logic        unused_lcr;

  assign unused_lcr = lcr[7];
  assign head       = fifo_mem[rd_ptr_q];
  assign data_mask  = 8'hFF >> (2'd3 - lcr[1:0]);
  assign stop_ticks = !stop_q ? 5'd15 : (wlen_q == 2'd0 ? 5'd23 : 5'd31);
  assign advance    = enable && (tick_q == 5'd0);
  assign last_bit   = (bit_cnt_q == (3'd4 + {1'b0, wlen_q}));

  always_comb begin
    push_ok  = tf_push && (count_q < DEPTH_C) && !tx_reset;
    pop_ok   = (state_q == POP) && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (tx_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + FIFO_COUNTER_W'(push_ok) - FIFO_COUNTER_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= wb_dat_i;
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    wlen_d    = wlen_q;
    pen_d     = pen_q;
    stop_d    = stop_q;
    stx_d     = 1'b1;

    unique case (state_q)
      START:  stx_d = 1'b0;
      DATA:   stx_d = shift_q[0];
      PARITY: stx_d = parity_q;
      default: stx_d = 1'b1;
    endcase

    unique case (state_q)
      IDLE: if (count_q != '0) state_d = POP;
      POP: begin
        // A flush landing between IDLE and POP leaves nothing to send.
        if (count_q != '0) begin
          shift_d  = head;
          wlen_d   = lcr[1:0];
          pen_d    = lcr[3];
          stop_d   = lcr[2];
          parity_d = lcr[5] ? ~lcr[4] : ((^(head & data_mask)) ^ ~lcr[4]);
          tick_d   = 5'd15;
          state_d  = START;
        end else begin
          state_d  = IDLE;
        end
      end
      START, DATA, PARITY, STOP: begin
        if (enable && tick_q != 5'd0) tick_d = tick_q - 5'd1;
        if (advance) begin
          tick_d = 5'd15;
          unique case (state_q)
            START: begin
              bit_cnt_d = 3'd0;
              state_d   = DATA;
            end
            DATA: begin
              shift_d   = {1'b0, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (last_bit) begin
                state_d = pen_q ? PARITY : STOP;
                if (!pen_q) tick_d = stop_ticks;
              end
            end
            PARITY: begin
              tick_d  = stop_ticks;
              state_d = STOP;
            end
            default: state_d = (count_q != '0) ? POP : IDLE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      wlen_q    <= '0;
      pen_q     <= 1'b0;
      stop_q    <= 1'b0;
      stx_q     <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      wlen_q    <= wlen_d;
      pen_q     <= pen_d;
      stop_q    <= stop_d;
      stx_q     <= stx_d;
    end
  end

  // Break overrides the line without disturbing the frame timing.
  assign stx_o    = lcr[6] ? 1'b0 : stx_q;
  assign tstate   = state_q;
  assign tf_count = count_q;

`ifdef UART_TX_OVERRUN_FLAG_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (lsr_mask || tx_reset) overrun_d = 1'b0;
    if (tf_push && count_q == DEPTH_C) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) overrun_q <= 1'b0;
    else          overrun_q <= overrun_d;
  end

  assign tf_overrun = overrun_q;
`else
  logic unused_lsr_mask;
  assign unused_lsr_mask = lsr_mask;
  assign tf_overrun      = 1'b0;
`endif

endmodule
